// File: rtl/ami_mem_responder.sv
// AMI memory-side endpoint: services AMIRequest beats from an on-chip word array and
// returns read data in order through a fixed-latency pipeline and a small response queue.
package ami_pkg;
    localparam int AMI_ADDR_WIDTH = 64;
    localparam int AMI_DATA_WIDTH = 512;
    localparam int AMI_SIZE_WIDTH = 8;

    typedef struct packed {
        logic                      valid;
        logic                      isWrite;
        logic [AMI_ADDR_WIDTH-1:0] addr;
        logic [AMI_DATA_WIDTH-1:0] data;
        logic [AMI_SIZE_WIDTH-1:0] size;
    } AMIRequest;

    typedef struct packed {
        logic                      valid;
        logic [AMI_DATA_WIDTH-1:0] data;
        logic [AMI_SIZE_WIDTH-1:0] size;
    } AMIResponse;
endpackage

module ami_mem_responder
    import ami_pkg::*;
#(
    parameter int LOG_WORDS     = 10,
    parameter int DATA_WIDTH    = 512,
    parameter int BYTE_OFF_BITS = 6,
    parameter int READ_LATENCY  = 3,
    parameter int LOG_RESP_Q    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  AMIRequest             mem_req_in,
    output logic                  mem_req_grant_out,
    output AMIResponse            mem_resp_out,
    input  logic                  mem_resp_grant_in,
    output logic [LOG_RESP_Q:0]   outstanding_reads
);
    localparam int WORDS   = 1 << LOG_WORDS;
    localparam int Q_DEPTH = 1 << LOG_RESP_Q;
    localparam int STAGES  = READ_LATENCY - 1;
    localparam int SIZE_W  = AMI_SIZE_WIDTH;
    localparam int IDX_HI  = BYTE_OFF_BITS + LOG_WORDS - 1;

    logic [DATA_WIDTH-1:0]              mem [WORDS];
    logic [LOG_WORDS-1:0]               req_idx;
    logic [LOG_RESP_Q:0]                cnt;
    logic                               wr_grant, rd_grant, resp_hs;

    logic [STAGES:0]                    vld_pipe;
    logic [STAGES:0][DATA_WIDTH-1:0]    data_pipe;
    logic [STAGES:0][SIZE_W-1:0]        size_pipe;

    logic [Q_DEPTH-1:0][DATA_WIDTH-1:0] q_data;
    logic [Q_DEPTH-1:0][SIZE_W-1:0]     q_size;
    logic [LOG_RESP_Q-1:0]              wr_ptr, rd_ptr;
    logic [LOG_RESP_Q:0]                q_cnt;
    logic                               q_push;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_req_in.addr[AMI_ADDR_WIDTH-1:IDX_HI+1],
                                mem_req_in.addr[BYTE_OFF_BITS-1:0]};

    // Upper address bits are dropped, so the array aliases across the address space.
    assign req_idx = mem_req_in.addr[IDX_HI:BYTE_OFF_BITS];

    // cnt never exceeds Q_DEPTH, so its top bit alone means "no credit left".
    assign wr_grant          = !rst && mem_req_in.valid &&  mem_req_in.isWrite;
    assign rd_grant          = !rst && mem_req_in.valid && !mem_req_in.isWrite && !cnt[LOG_RESP_Q];
    assign mem_req_grant_out = wr_grant || rd_grant;

    assign resp_hs           = (q_cnt != '0) && mem_resp_grant_in;
    assign outstanding_reads = cnt;

    always_ff @(posedge clk) begin
        if (wr_grant)
            mem[req_idx] <= mem_req_in.data;
    end

    // Stage 0 is the registered array read; the rest are plain delay stages.
    generate
        if (STAGES > 0) begin : g_pipe
            always_ff @(posedge clk) begin
                if (rst) vld_pipe <= '0;
                else     vld_pipe <= {vld_pipe[STAGES-1:0], rd_grant};
                data_pipe <= {data_pipe[STAGES-1:0], mem[req_idx]};
                size_pipe <= {size_pipe[STAGES-1:0], mem_req_in.size};
            end
        end else begin : g_single
            always_ff @(posedge clk) begin
                if (rst) vld_pipe <= '0;
                else     vld_pipe <= rd_grant;
                data_pipe <= mem[req_idx];
                size_pipe <= mem_req_in.size;
            end
        end
    endgenerate

    assign q_push = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({rd_grant, resp_hs})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Credits reserve a queue slot at grant time, so a push never meets a full queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (q_push)  wr_ptr <= wr_ptr + 1'b1;
            if (resp_hs) rd_ptr <= rd_ptr + 1'b1;
            case ({q_push, resp_hs})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (q_push) begin
            q_data[wr_ptr] <= data_pipe[STAGES];
            q_size[wr_ptr] <= size_pipe[STAGES];
        end
    end

    always_comb begin
        mem_resp_out       = '0;
        mem_resp_out.valid = (q_cnt != '0);
        mem_resp_out.data  = q_data[rd_ptr];
        mem_resp_out.size  = q_size[rd_ptr];
    end
endmodule

// File: tb/tb_ami_mem_responder.sv
// Bench for ami_mem_responder: directed protocol scenarios plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_ami_mem_responder;
    import ami_pkg::*;

    localparam int L     = 3;
    localparam int LQ    = 2;
    localparam int DEPTH = 4;
    localparam int LW    = 10;
    localparam int BO    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          resp_grant = 1'b0;
    logic          req_grant;
    AMIRequest     req = '0;
    AMIResponse    resp;
    logic [LQ:0]   outst;

    int n_cmp = 0;
    int n_err = 0;

    ami_mem_responder #(
        .LOG_WORDS(LW), .DATA_WIDTH(512), .BYTE_OFF_BITS(BO),
        .READ_LATENCY(L), .LOG_RESP_Q(LQ)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req_in(req), .mem_req_grant_out(req_grant),
        .mem_resp_out(resp), .mem_resp_grant_in(resp_grant),
        .outstanding_reads(outst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: a read granted in cycle n becomes visible at cycle n+L+1 and waits in order.
    typedef struct {
        int           ready;
        logic [511:0] data;
        logic [7:0]   size;
        bit           known;
    } pend_t;

    pend_t        pend[$];
    logic [511:0] mmem [int];
    logic [31:0]  hs[$];
    int           mcnt  = 0;
    int           mcyc  = 0;
    bit           armed = 0;

    always @(negedge clk) begin
        bit    eg, ev;
        int    idx;
        pend_t p;
        eg  = !rst && req.valid && (req.isWrite || mcnt < DEPTH);
        ev  = (pend.size() > 0) && (pend[0].ready <= mcyc);
        idx = int'(req.addr[BO+LW-1:BO]);
        if (armed) begin
            chk("grant", 512'(req_grant), 512'(eg));
            chk("resp_valid", 512'(resp.valid), 512'(ev));
            chk("outstanding", 512'(outst), 512'(mcnt));
            if (ev && pend[0].known) begin
                chk("resp_data", resp.data, pend[0].data);
                chk("resp_size", 512'(resp.size), 512'(pend[0].size));
            end
        end
        if (!rst && resp.valid && resp_grant)
            hs.push_back(resp.data[31:0]);
        if (rst) begin
            pend.delete();
            mcnt  = 0;
            armed = 1;
        end else if (armed) begin
            if (ev && resp_grant) begin
                void'(pend.pop_front());
                mcnt--;
            end
            if (eg && req.isWrite) begin
                mmem[idx] = req.data;
            end else if (eg) begin
                p.ready = mcyc + L + 1;
                p.known = mmem.exists(idx);
                p.data  = p.known ? mmem[idx] : '0;
                p.size  = req.size;
                pend.push_back(p);
                mcnt++;
            end
        end
        mcyc++;
    end

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_req(input bit v, input bit w, input logic [63:0] a, input logic [511:0] d);
        req.valid   = v;
        req.isWrite = w;
        req.addr    = a;
        req.data    = d;
        req.size    = 8'd64;
    endtask

    // Present a request and hold it until granted; reports the stall cycles.
    task automatic issue(input bit w, input logic [63:0] a, input logic [511:0] d, output int waited);
        set_req(1'b1, w, a, d);
        waited = 0;
        @(negedge clk);
        while (!req_grant && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_grant) chk("issue_timeout", 512'(req_grant), 512'(1));
        @(posedge clk); #1;
        req.valid = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int t = 0;
        while (hs.size() < n && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("hs_count", 512'(hs.size()), 512'(n));
    endtask

    initial begin
        int           w, gcount;
        logic [511:0] a_val, b_val;
        logic [63:0]  addr;
        a_val = {16{32'hDEADBEEF}};
        b_val = {16{32'hB0B0CAFE}};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outstanding", 512'(outst), 512'(0));
        chk("reset_resp_valid", 512'(resp.valid), 512'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 32; i++) issue(1'b1, 64'(i * 64), rnd512(), w);

        // single write then read
        resp_grant = 1'b1;
        issue(1'b1, 64'h40, a_val, w);
        chk("wr_wait", 512'(w), 512'(0));
        issue(1'b0, 64'h40, '0, w);
        chk("rd_wait", 512'(w), 512'(0));
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("latency_valid", 512'(resp.valid), 512'(k == 4));
            if (k == 4) chk("rd_data_A", resp.data, a_val);
        end
        @(negedge clk);
        chk("single_outstanding", 512'(outst), 512'(0));
        @(posedge clk); #1;

        // streaming
        for (int i = 0; i < 16; i++) issue(1'b1, 64'(i * 64), 512'(i), w);
        hs.delete();
        for (int i = 0; i < 16; i++) issue(1'b0, 64'(i * 64), '0, w);
        wait_hs(16);
        for (int i = 0; i < 16 && i < hs.size(); i++) chk("stream_order", 512'(hs[i]), 512'(i));

        // backpressure
        resp_grant = 1'b0;
        hs.delete();
        gcount = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 1'b0, 64'(i * 64), '0);
            @(negedge clk);
            if (req_grant) gcount++;
            @(posedge clk); #1;
        end
        req.valid = 1'b0;
        chk("bp_grants", 512'(gcount), 512'(4));
        @(negedge clk);
        chk("bp_outstanding", 512'(outst), 512'(4));
        @(posedge clk); #1;
        issue(1'b1, 64'(40 * 64), rnd512(), w);
        chk("bp_write_wait", 512'(w), 512'(0));
        repeat (3) begin
            @(negedge clk);
            chk("bp_head_hold", resp.data, 512'(0));
            chk("bp_head_valid", 512'(resp.valid), 512'(1));
        end
        @(posedge clk); #1;

        // handshake coinciding with a read at full credit
        set_req(1'b1, 1'b0, 64'(4 * 64), '0);
        resp_grant = 1'b1;
        @(negedge clk);
        chk("sim_blocked", 512'(req_grant), 512'(0));
        @(posedge clk); #1;
        resp_grant = 1'b0;
        @(negedge clk);
        chk("sim_granted", 512'(req_grant), 512'(1));
        @(posedge clk); #1;
        req.valid = 1'b0;
        @(negedge clk);
        chk("sim_outstanding", 512'(outst), 512'(4));
        @(posedge clk); #1;
        resp_grant = 1'b1;
        wait_hs(5);
        for (int i = 0; i < 5 && i < hs.size(); i++) chk("bp_drain_order", 512'(hs[i]), 512'(i));
        issue(1'b0, 64'(5 * 64), '0, w);
        wait_hs(6);
        if (hs.size() > 5) chk("bp_read5", 512'(hs[5]), 512'(5));

        // aliasing
        hs.delete();
        issue(1'b1, 64'h10040, b_val, w);
        issue(1'b0, 64'h40, '0, w);
        wait_hs(1);
        if (hs.size() > 0) chk("alias_data", 512'(hs[0]), 512'(32'hB0B0CAFE));

        // reset with reads in flight
        resp_grant = 1'b0;
        hs.delete();
        for (int i = 2; i < 5; i++) issue(1'b0, 64'(i * 64), '0, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outstanding", 512'(outst), 512'(0));
        @(posedge clk); #1;
        resp_grant = 1'b1;
        issue(1'b0, 64'h40, '0, w);
        repeat (12) @(posedge clk);
        #1;
        chk("rst_resp_count", 512'(hs.size()), 512'(1));
        if (hs.size() > 0) chk("rst_resp_data", 512'(hs[0]), 512'(32'hB0B0CAFE));

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            addr = {$urandom, $urandom};
            addr[BO+LW-1:BO] = 10'($urandom_range(0, 31));
            set_req($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, addr, rnd512());
            req.size   = 8'($urandom_range(0, 255));
            resp_grant = $urandom_range(0, 9) < 6;
            rst        = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        rst        = 1'b0;
        req.valid  = 1'b0;
        resp_grant = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("final_outstanding", 512'(outst), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
